// File: rtl/rd_stream_buffer_if.sv
// Handshake/bus bundle for rd_stream_buffer: load port, stream config and
// the valid/ready output stream. master = loader/consumer side, slave = buffer.
`timescale 1ns/1ps
interface rd_stream_buffer_if #(
  parameter int ADDR_LEN = 5,
  parameter int DATA_LEN = 32,
  parameter int PASS_W   = 8
);
  logic                ld_en;
  logic [ADDR_LEN-1:0] ld_addr;
  logic [DATA_LEN-1:0] ld_data;
  logic [ADDR_LEN-1:0] cfg_last;
  logic                cfg_loop;
  logic                start;
  logic                out_ready;
  logic                out_valid;
  logic [DATA_LEN-1:0] out_data;
  logic                busy;
  logic                done;
  logic [PASS_W-1:0]   pass_cnt;

  modport master (
    output ld_en, ld_addr, ld_data, cfg_last, cfg_loop, start, out_ready,
    input  out_valid, out_data, busy, done, pass_cnt
  );

  modport slave (
    input  ld_en, ld_addr, ld_data, cfg_last, cfg_loop, start, out_ready,
    output out_valid, out_data, busy, done, pass_cnt
  );
endinterface

// File: rtl/rd_stream_buffer.sv
// rd_stream_buffer: loadable word buffer streamed out in address order
// (0..last), one word per cycle, in loop or one-shot mode, with a
// saturating completed-pass counter and a valid/ready output.
`timescale 1ns/1ps
module rd_stream_buffer #(
  parameter int ADDR_LEN = 5,
  parameter int DATA_LEN = 32,
  parameter int PE_ID    = 0,
  parameter int PASS_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  rd_stream_buffer_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_LEN;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    DONE
  } stateT;

  stateT               state;
  stateT               stateNxt;
  logic [DATA_LEN-1:0] mem [DEPTH];
  logic [ADDR_LEN-1:0] head;
  logic [ADDR_LEN-1:0] headNxt;
  logic [ADDR_LEN-1:0] lastQ;
  logic [ADDR_LEN-1:0] rdAddr;
  logic                loopQ;
  logic                fire;
  logic                atLast;
  logic                memRead;
  logic                passInc;
  logic                busyInt;

  // PE_ID only tags the instance here; buffer contents arrive via the load port.
  logic unusedPeId;
  assign unusedPeId = ^PE_ID;

  assign fire    = bus.out_valid & bus.out_ready;
  assign atLast  = (head == lastQ);
  assign headNxt = atLast ? '0 : head + 1'b1;
  assign busyInt = (state == PRIME) || (state == RUN);
  assign bus.busy = busyInt;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNxt;
  end

  // Next state and read control; start overrides everything, including a
  // coincident fire, which is then neither consumed nor counted.
  always_comb begin
    stateNxt = state;
    memRead  = 1'b0;
    rdAddr   = head;
    passInc  = 1'b0;
    unique case (state)
      IDLE, DONE: ;
      PRIME: begin
        stateNxt = RUN;
        memRead  = 1'b1;
        rdAddr   = '0;
      end
      RUN: begin
        if (fire) begin
          memRead = 1'b1;
          rdAddr  = headNxt;
          passInc = atLast;
          if (atLast && !loopQ) stateNxt = DONE;
        end
      end
      default: stateNxt = IDLE;
    endcase
    if (bus.start) begin
      stateNxt = PRIME;
      memRead  = 1'b0;
      passInc  = 1'b0;
    end
  end

  // Stream datapath: head pointer, captured config, output register, status.
  // out_valid is registered from the next state so it is high exactly in RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head          <= '0;
      lastQ         <= '0;
      loopQ         <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.done      <= 1'b0;
      bus.pass_cnt  <= '0;
    end else begin
      bus.out_valid <= (stateNxt == RUN);
      if (bus.start) begin
        head         <= '0;
        lastQ        <= bus.cfg_last;
        loopQ        <= bus.cfg_loop;
        bus.pass_cnt <= '0;
        bus.done     <= 1'b0;
      end else if ((state == RUN) && fire) begin
        head <= headNxt;
        if (passInc && (bus.pass_cnt != '1)) bus.pass_cnt <= bus.pass_cnt + 1'b1;
        if (stateNxt == DONE) bus.done <= 1'b1;
      end
      if (memRead) bus.out_data <= mem[rdAddr];
    end
  end

  // Load port: writes are accepted only while no stream is in flight.
  always_ff @(posedge clk) begin
    if (bus.ld_en && !busyInt) mem[bus.ld_addr] <= bus.ld_data;
  end
endmodule
